// File: rtl/heartbeat_pkg.sv
// heartbeat_pkg: shared types and constants for the heartbeat generator.
//   mode_t          - 2-bit channel waveform selector
//   MAX_CH          - largest supported channel count
//   mode_drives_pad - true when a mode actively drives its pad
package heartbeat_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_PATTERN = 2'd3
    } mode_t;

    localparam int unsigned MAX_CH = 16;

    function automatic logic mode_drives_pad(input mode_t m);
        return (m != MODE_OFF);
    endfunction

endpackage

// File: rtl/heartbeat_chan.sv
// heartbeat_chan: one heartbeat channel (config registers, prescaler,
// PWM phase counter and pattern rotator).
// Optional macro HEARTBEAT_SYNC_EN adds i_sync (global phase realignment).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_we                    channel-local config write strobe
//   i_mode/i_div/i_duty/i_pat  config values captured on i_we
//   i_sync                  (HEARTBEAT_SYNC_EN) restart from stored config
//   o_sig, o_oe             registered waveform and output-enable
module heartbeat_chan
    import heartbeat_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int PWM_W = 4,
    parameter int PAT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    input  logic [PWM_W-1:0] i_duty,
    input  logic [PAT_W-1:0] i_pat,
`ifdef HEARTBEAT_SYNC_EN
    input  logic             i_sync,
`endif
    output logic             o_sig,
    output logic             o_oe
);

    mode_t            r_mode, w_mode;
    logic [DIV_W-1:0] r_div, w_div, r_cnt, w_cnt;
    logic [PWM_W-1:0] r_duty, w_duty, r_ph, w_ph, w_ph_inc;
    logic [PAT_W-1:0] r_pat, w_pat, r_work, w_work, w_work_rot;
    logic             r_sig, w_sig, r_oe, w_oe, w_tick;

    // Next-state: config write beats sync, sync beats the running prescaler.
    always_comb begin
        w_mode     = r_mode;
        w_div      = r_div;
        w_duty     = r_duty;
        w_pat      = r_pat;
        w_cnt      = r_cnt;
        w_ph       = r_ph;
        w_work     = r_work;
        w_sig      = r_sig;
        w_oe       = r_oe;
        w_tick     = (r_cnt == r_div) && (r_mode != MODE_OFF);
        w_ph_inc   = r_ph + {{(PWM_W-1){1'b0}}, 1'b1};
        w_work_rot = {r_work[0], r_work[PAT_W-1:1]};
        if (i_we) begin
            w_mode = mode_t'(i_mode);
            w_div  = i_div;
            w_duty = i_duty;
            w_pat  = i_pat;
            w_cnt  = '0;
            w_ph   = '0;
            w_work = i_pat;
            w_sig  = 1'b0;
            w_oe   = mode_drives_pad(mode_t'(i_mode));
        end
`ifdef HEARTBEAT_SYNC_EN
        else if (i_sync) begin
            w_cnt  = '0;
            w_ph   = '0;
            w_work = r_pat;
            w_sig  = 1'b0;
        end
`endif
        else if (r_mode == MODE_OFF) begin
            w_cnt = '0;
            w_ph  = '0;
            w_sig = 1'b0;
            w_oe  = 1'b0;
        end else if (w_tick) begin
            w_cnt = '0;
            case (r_mode)
                MODE_SQUARE: w_sig = ~r_sig;
                MODE_PWM: begin
                    w_ph  = w_ph_inc;
                    w_sig = (w_ph_inc < r_duty);
                end
                MODE_PATTERN: begin
                    w_work = w_work_rot;
                    w_sig  = w_work_rot[0];
                end
                default: w_sig = 1'b0;
            endcase
        end else begin
            w_cnt = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Channel state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= MODE_OFF;
            r_div  <= '0;
            r_duty <= '0;
            r_pat  <= '0;
            r_cnt  <= '0;
            r_ph   <= '0;
            r_work <= '0;
            r_sig  <= 1'b0;
            r_oe   <= 1'b0;
        end else begin
            r_mode <= w_mode;
            r_div  <= w_div;
            r_duty <= w_duty;
            r_pat  <= w_pat;
            r_cnt  <= w_cnt;
            r_ph   <= w_ph;
            r_work <= w_work;
            r_sig  <= w_sig;
            r_oe   <= w_oe;
        end
    end

    assign o_sig = r_sig;
    assign o_oe  = r_oe;

endmodule

// File: rtl/heartbeat_gen.sv
// heartbeat_gen: multi-channel heartbeat/pad waveform generator.
// Optional macro HEARTBEAT_SYNC_EN adds sync_clr to phase-align all channels.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cfg_we, cfg_ch                   single-cycle write strobe and target channel
//   cfg_mode/cfg_div/cfg_duty/cfg_pat  channel configuration
//   sync_clr                         (HEARTBEAT_SYNC_EN) global realignment
//   sig_out, sig_oe                  registered per-channel pad A / OE
module heartbeat_gen
    import heartbeat_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = 16,
    parameter  int PWM_W  = 4,
    parameter  int PAT_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [PWM_W-1:0]  cfg_duty,
    input  logic [PAT_W-1:0]  cfg_pat,
`ifdef HEARTBEAT_SYNC_EN
    input  logic              sync_clr,
`endif
    output logic [NUM_CH-1:0] sig_out,
    output logic [NUM_CH-1:0] sig_oe
);

    // Indices at or beyond NUM_CH (possible when NUM_CH is not a power of two) are dropped.
    logic w_ch_ok;
    assign w_ch_ok = (int'(cfg_ch) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_we;
        assign w_we = cfg_we && w_ch_ok && (cfg_ch == CH_W'(g));

        heartbeat_chan #(
            .DIV_W (DIV_W),
            .PWM_W (PWM_W),
            .PAT_W (PAT_W)
        ) u_chan (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_we    (w_we),
            .i_mode  (cfg_mode),
            .i_div   (cfg_div),
            .i_duty  (cfg_duty),
            .i_pat   (cfg_pat),
`ifdef HEARTBEAT_SYNC_EN
            .i_sync  (sync_clr),
`endif
            .o_sig   (sig_out[g]),
            .o_oe    (sig_oe[g])
        );
    end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Self-checking bench for heartbeat_gen. Expected waveforms come from a
// closed-form model: edges elapsed since the last write (or sync) give the
// tick count, and the tick count gives the output directly.
module tb_heartbeat_gen;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 16;
    localparam int PWM_W  = 4;
    localparam int PAT_W  = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [1:0]        cfg_mode = 2'd0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [PWM_W-1:0]  cfg_duty = '0;
    logic [PAT_W-1:0]  cfg_pat = '0;
    logic              sync_clr = 1'b0;
    logic [NUM_CH-1:0] sig_out;
    logic [NUM_CH-1:0] sig_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    heartbeat_gen #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .PWM_W  (PWM_W),
        .PAT_W  (PAT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_div  (cfg_div),
        .cfg_duty (cfg_duty),
        .cfg_pat  (cfg_pat),
`ifdef HEARTBEAT_SYNC_EN
        .sync_clr (sync_clr),
`endif
        .sig_out  (sig_out),
        .sig_oe   (sig_oe)
    );

    // ---------------- reference model ----------------
    int             m_mode [NUM_CH];
    int             m_div  [NUM_CH];
    int             m_duty [NUM_CH];
    logic [PAT_W-1:0] m_pat [NUM_CH];
    int             m_n    [NUM_CH];
    bit             m_live [NUM_CH];

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_live[c] = 1'b0;
            m_mode[c] = 0;
            m_n[c]    = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode);
                m_div[c]  = int'(cfg_div);
                m_duty[c] = int'(cfg_duty);
                m_pat[c]  = cfg_pat;
                m_n[c]    = 0;
                m_live[c] = 1'b1;
            end else if (sync_clr) begin
                m_n[c] = 0;
            end else if (m_live[c]) begin
                m_n[c] = m_n[c] + 1;
            end
        end
    endfunction

    function automatic logic exp_sig(int c);
        int t;
        if (!m_live[c] || m_mode[c] == 0) return 1'b0;
        t = m_n[c] / (m_div[c] + 1);
        case (m_mode[c])
            1: return (t % 2) == 1;
            2: return (t == 0) ? 1'b0 : ((t % (1 << PWM_W)) < m_duty[c]);
            default: return (t == 0) ? 1'b0 : m_pat[c][t % PAT_W];
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] exp_out();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = exp_sig(c);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_oe();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_live[c] && (m_mode[c] != 0);
        return v;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cfg_we   = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic write(int ch, int mode, int dv, int duty, int pat);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_div  = DIV_W'(dv);
        cfg_duty = PWM_W'(duty);
        cfg_pat  = PAT_W'(pat);
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sig_out !== '0 || sig_oe !== '0) begin
            errors++;
            $display("FAIL reset_hold out=%b oe=%b exp=0/0", sig_out, sig_oe);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sig_out !== '0 || sig_oe !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d out=%b oe=%b exp=0/0", i, sig_out, sig_oe);
            end
        end
    endtask

    task automatic test_square();
        write(0, 1, 3, 0, 0);
        checks++;
        if (sig_oe !== 5'b00001 || sig_out !== 5'b00000) begin
            errors++;
            $display("FAIL square_first out=%b oe=%b exp=00000/00001", sig_out, sig_oe);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                errors++;
                $display("FAIL square cyc%0d out=%b oe=%b exp=%b/%b", i, sig_out, sig_oe, exp_out(), exp_oe());
            end
        end
    endtask

    task automatic test_pwm();
        int duties [3] = '{5, 0, 15};
        int highs [3]  = '{5, 0, 15};
        int cnt;
        for (int d = 0; d < 3; d++) begin
            write(1, 2, 0, duties[d], 0);
            cnt = 0;
            for (int i = 0; i < 32; i++) begin
                step();
                if (i >= 16) cnt += int'(sig_out[1]);
                checks++;
                if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                    errors++;
                    $display("FAIL pwm duty%0d cyc%0d out=%b oe=%b exp=%b/%b", duties[d], i, sig_out, sig_oe, exp_out(), exp_oe());
                end
            end
            checks++;
            if (cnt != highs[d]) begin
                errors++;
                $display("FAIL pwm_highs duty%0d got=%0d exp=%0d", duties[d], cnt, highs[d]);
            end
        end
    endtask

    task automatic test_pattern();
        write(2, 3, 1, 0, 8'hB1);
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                errors++;
                $display("FAIL pattern cyc%0d out=%b oe=%b exp=%b/%b", i, sig_out, sig_oe, exp_out(), exp_oe());
            end
        end
        // All-ones and all-zero patterns on another channel.
        write(4, 3, 0, 0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (sig_out[4] !== (i >= 0) || sig_out !== exp_out()) begin
                errors++;
                $display("FAIL pattern_ones cyc%0d out=%b exp=%b", i, sig_out, exp_out());
            end
        end
        write(4, 3, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (sig_out[4] !== 1'b0 || sig_oe[4] !== 1'b1) begin
                errors++;
                $display("FAIL pattern_zero cyc%0d out=%b oe=%b exp=0/1", i, sig_out[4], sig_oe[4]);
            end
        end
    endtask

    task automatic test_ignored_write();
        write(5, 2, 0, 7, 8'h55);
        write(7, 1, 1, 3, 8'hAA);
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                errors++;
                $display("FAIL ignored_write cyc%0d out=%b oe=%b exp=%b/%b", i, sig_out, sig_oe, exp_out(), exp_oe());
            end
        end
    endtask

    task automatic test_write_on_tick();
        int guard = 0;
        write(0, 1, 3, 0, 0);
        // Advance until the next edge would be a tick on ch0.
        while ((m_n[0] % 4) != 3 && guard < 16) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 16) begin
            errors++;
            $display("FAIL tick_align guard=%0d exp<16", guard);
        end
        write(0, 1, 5, 0, 0);
        checks++;
        if (sig_out[0] !== 1'b0 || sig_oe[0] !== 1'b1) begin
            errors++;
            $display("FAIL write_on_tick out=%b oe=%b exp=0/1", sig_out[0], sig_oe[0]);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                errors++;
                $display("FAIL after_tick_write cyc%0d out=%b oe=%b exp=%b/%b", i, sig_out, sig_oe, exp_out(), exp_oe());
            end
        end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sig_out !== '0 || sig_oe !== '0) begin
            errors++;
            $display("FAIL async_reset out=%b oe=%b exp=0/0", sig_out, sig_oe);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (sig_out !== '0 || sig_oe !== '0) begin
                errors++;
                $display("FAIL post_reset cyc%0d out=%b oe=%b exp=0/0", i, sig_out, sig_oe);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = CH_W'($urandom_range(7, 0));
                cfg_mode = 2'($urandom_range(3, 0));
                cfg_div  = DIV_W'($urandom_range(4, 0));
                cfg_duty = PWM_W'($urandom);
                cfg_pat  = PAT_W'($urandom);
            end
            step();
            checks++;
            if (sig_out !== exp_out() || sig_oe !== exp_oe()) begin
                errors++;
                $display("FAIL random cyc%0d out=%b oe=%b exp=%b/%b", i, sig_out, sig_oe, exp_out(), exp_oe());
            end
        end
    endtask

`ifdef HEARTBEAT_SYNC_EN
    task automatic test_sync();
        write(0, 1, 2, 0, 0);
        step();
        write(3, 1, 2, 0, 0);
        sync_clr = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 3'd1;
        cfg_mode = 2'd3;
        cfg_div  = 16'd0;
        cfg_pat  = 8'h0F;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (sig_out !== exp_out() || sig_out[0] !== sig_out[3]) begin
                errors++;
                $display("FAIL sync cyc%0d out=%b exp=%b", i, sig_out, exp_out());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_square();
        test_pwm();
        test_pattern();
        test_ignored_write();
        test_write_on_tick();
        test_reset_mid();
        test_random();
`ifdef HEARTBEAT_SYNC_EN
        test_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
